// File: rtl/i2c_master_arbiter_if.sv
// i2c_master_arbiter_if: link between the arbiter and the shared i2c_master
interface i2c_master_arbiter_if;
    logic       m_start;
    logic       m_rnw;
    logic [6:0] m_addr;
    logic [2:0] m_size;
    logic [7:0] m_wdata;
    logic       m_wvalid;
    logic       m_ready;
    logic       m_busy;
    logic       m_data_available;
    logic       m_data_request;
    logic [7:0] m_rdata;
    modport master (
        output m_start, m_rnw, m_addr, m_size, m_wdata, m_wvalid,
        input  m_ready, m_busy, m_data_available, m_data_request, m_rdata
    );
    modport slave (
        input  m_start, m_rnw, m_addr, m_size, m_wdata, m_wvalid,
        output m_ready, m_busy, m_data_available, m_data_request, m_rdata
    );
endinterface

// File: rtl/i2c_master_arbiter.sv
// i2c_master_arbiter: round-robin sharing of one i2c_master among N requesters
module i2c_master_arbiter #(
    parameter int N       = 4,
    parameter int TIMEOUT = 4096,
    parameter int TW      = 13
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic [N-1:0]         req_rnw,
    input  logic [7*N-1:0]       req_addr,
    input  logic [3*N-1:0]       req_size,
    input  logic [8*N-1:0]       req_wdata,
    input  logic [N-1:0]         req_wvalid,
    output logic [N-1:0]         grant,
    output logic [N-1:0]         wreq,
    output logic [N-1:0]         rvalid,
    output logic [7:0]           rdata,
    output logic [N-1:0]         done,
    output logic [N-1:0]         err,
    i2c_master_arbiter_if.master m
);
    localparam int PW = N > 1 ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, LAUNCH, RUN, FINISH} state_t;

    state_t        state, state_n;
    logic [1:0]    ready_q, busy_q, avail_q;
    logic          ready_s, busy_s, avail_s, avail_d, rd_rise, eflag;
    logic [TW-1:0] cnt;
    logic [PW-1:0] ptr, gi, win;

    assign ready_s = ready_q[1];
    assign busy_s  = busy_q[1];
    assign avail_s = avail_q[1];
    assign rd_rise = state == RUN && avail_s && !avail_d;

    assign m.m_start  = state == LAUNCH;
    assign m.m_wdata  = |grant ? req_wdata[8*gi +: 8] : 8'h00;
    assign m.m_wvalid = |grant && req_wvalid[gi];
    assign wreq       = grant & {N{m.m_data_request}};
    assign done       = (state == FINISH && !eflag) ? grant : '0;
    assign err        = (state == FINISH && eflag) ? grant : '0;

    // two-flop synchronisers for the master's slow status lines
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_q <= '0;
            busy_q  <= '0;
            avail_q <= '0;
        end else begin
            ready_q <= {ready_q[0], m.m_ready};
            busy_q  <= {busy_q[0], m.m_busy};
            avail_q <= {avail_q[0], m.m_data_available};
        end
    end

    // first requesting index at or above ptr, wrapping at N
    always_comb begin
        win = ptr;
        for (int k = N - 1; k >= 0; k--)
            if (req[(int'(ptr) + k) % N]) win = PW'((int'(ptr) + k) % N);
    end

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // next-state: launch wins over timeout when both happen on the same cycle
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = (|req && !busy_s) ? LAUNCH : IDLE;
            LAUNCH:  state_n = !ready_s ? RUN : (cnt == TW'(TIMEOUT - 1)) ? FINISH : LAUNCH;
            RUN:     state_n = ready_s ? FINISH : RUN;
            default: state_n = IDLE;
        endcase
    end

    // grant/descriptor latch, timeout counter, pointer and read capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant    <= '0;
            gi       <= '0;
            ptr      <= '0;
            cnt      <= '0;
            eflag    <= 1'b0;
            m.m_rnw  <= 1'b0;
            m.m_addr <= '0;
            m.m_size <= '0;
            rdata    <= '0;
            rvalid   <= '0;
            avail_d  <= 1'b0;
        end else begin
            avail_d <= avail_s;
            rvalid  <= rd_rise ? grant : '0;
            if (rd_rise) rdata <= m.m_rdata;
            case (state)
                IDLE: if (state_n == LAUNCH) begin
                    grant    <= N'(1) << win;
                    gi       <= win;
                    m.m_rnw  <= req_rnw[win];
                    m.m_addr <= req_addr[7*win +: 7];
                    m.m_size <= req_size[3*win +: 3];
                    eflag    <= 1'b0;
                    cnt      <= '0;
                end
                LAUNCH: begin
                    cnt <= cnt + 1'b1;
                    if (ready_s && cnt == TW'(TIMEOUT - 1)) eflag <= 1'b1;
                end
                FINISH: begin
                    grant <= '0;
                    ptr   <= (gi == PW'(N - 1)) ? '0 : gi + 1'b1;
                    cnt   <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_master_arbiter.sv
// tb_i2c_master_arbiter: directed and randomized checks against a behavioural model
module tb_i2c_master_arbiter;
    localparam int N = 4;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [N-1:0] req = '0, req_rnw, req_wvalid = '1;
    logic [7*N-1:0] req_addr;
    logic [3*N-1:0] req_size;
    logic [8*N-1:0] req_wdata;
    logic [N-1:0] grant, wreq, rvalid, done, err;
    logic [7:0] rdata;

    logic [6:0] addr_a [N];
    logic [2:0] size_a [N];
    logic       rnw_a [N];
    logic [7:0] wdata_a [N];
    logic [7:0] rd_bytes [8];

    logic mready = 1'b1, mbusy = 1'b0, mavail = 1'b0, mdreq = 1'b0, hold_busy = 1'b0, hang = 1'b0;
    logic [7:0] mrdata = 8'h00;
    logic act = 1'b0, mrnw = 1'b0;
    int t = 0, nb = 0;

    int checks = 0, errors = 0, exp_ptr = 0, wbad = 0;
    logic [N-1:0] exp_grant = '0;
    logic [N-1:0] rv_q[$];
    logic [7:0]   rd_q[$];

    i2c_master_arbiter_if m();

    assign m.m_ready          = mready;
    assign m.m_busy           = mbusy | hold_busy;
    assign m.m_data_available = mavail;
    assign m.m_data_request   = mdreq;
    assign m.m_rdata          = mrdata;

    i2c_master_arbiter #(.N(N), .TIMEOUT(TO), .TW(5)) dut (
        .clk(clk), .rst(rst), .req(req), .req_rnw(req_rnw), .req_addr(req_addr),
        .req_size(req_size), .req_wdata(req_wdata), .req_wvalid(req_wvalid),
        .grant(grant), .wreq(wreq), .rvalid(rvalid), .rdata(rdata),
        .done(done), .err(err), .m(m)
    );

    always #5 clk = ~clk;

    // pack per-requester descriptors onto the flat buses
    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_addr[7*i +: 7]  = addr_a[i];
            req_size[3*i +: 3]  = size_a[i];
            req_rnw[i]          = rnw_a[i];
            req_wdata[8*i +: 8] = wdata_a[i];
        end
    end

    // master model: accept start, go busy, move nb bytes six cycles apart, return to ready
    always @(negedge clk) begin
        if (rst) begin
            act = 1'b0; t = 0; mready = 1'b1; mbusy = 1'b0; mavail = 1'b0; mdreq = 1'b0;
        end else if (!act) begin
            if (m.m_start && mready && !hang) begin
                act = 1'b1; t = 0; nb = int'(m.m_size); mrnw = m.m_rnw;
            end
        end else begin
            t++;
            mready = t < 2 || t >= 8 + 6*nb;
            mbusy  = !mready;
            mdreq  = !mrnw && t >= 6 && (t - 6) / 6 < nb && (t - 6) % 6 == 0;
            mavail = mrnw && t >= 6 && (t - 6) / 6 < nb && (t - 6) % 6 < 3;
            if (mrnw && t >= 6 && (t - 6) / 6 < nb && (t - 6) % 6 == 0) mrdata = rd_bytes[(t - 6) / 6];
            if (t >= 8 + 6*nb) act = 1'b0;
        end
    end

    // observe byte pulses and write-request routing between clock edges
    always @(negedge clk) begin
        #2;
        if (rvalid != '0) begin
            rv_q.push_back(rvalid);
            rd_q.push_back(rdata);
        end
        if (!rst && wreq !== (mdreq ? exp_grant : '0)) wbad++;
    end

    function automatic int winner(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
        return 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic serve(input int g, input string tag);
        for (int i = 0; i < 40 && grant == '0; i++) @(negedge clk);
        chk({tag, "_grant"}, grant, 1 << g);
        exp_grant = N'(1) << g;
        chk({tag, "_addr"}, m.m_addr, addr_a[g]);
        chk({tag, "_size"}, m.m_size, size_a[g]);
        chk({tag, "_rnw"}, m.m_rnw, rnw_a[g]);
        chk({tag, "_wdata"}, {m.m_wvalid, m.m_wdata}, {1'b1, wdata_a[g]});
        rv_q.delete();
        rd_q.delete();
        for (int i = 0; i < 400 && done == '0 && err == '0; i++) @(negedge clk);
        chk({tag, "_done"}, {err, done}, 1 << g);
        chk({tag, "_start_low"}, m.m_start, 0);
        if (rnw_a[g]) begin
            chk({tag, "_rcount"}, rv_q.size(), size_a[g]);
            for (int b = 0; b < rv_q.size() && b < 8; b++) begin
                chk({tag, "_rvalid"}, rv_q[b], 1 << g);
                chk({tag, "_rdata"}, rd_q[b], rd_bytes[b]);
            end
        end
        chk({tag, "_wreq"}, wbad, 0);
        req[g] = 1'b0;
        exp_ptr = (g + 1) % N;
        @(negedge clk);
        exp_grant = '0;
        chk({tag, "_released"}, grant, 0);
    endtask

    initial begin
        int n;
        logic [N-1:0] pat;
        for (int i = 0; i < N; i++) begin
            addr_a[i] = 7'(8'h10 + i); size_a[i] = 3'd1; rnw_a[i] = 1'b0; wdata_a[i] = 8'(i);
        end
        for (int b = 0; b < 8; b++) rd_bytes[b] = 8'(b);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_out", {grant, wreq, rvalid, done, err, m.m_start, m.m_wvalid}, 0);
        chk("reset_data", {rdata, m.m_wdata, m.m_addr, m.m_size}, 0);

        addr_a[0] = 7'h50; size_a[0] = 3'd2; wdata_a[0] = 8'hA5;
        req = 4'b0001;
        @(negedge clk);
        chk("latency_start", {m.m_start, grant}, {1'b1, 4'b0001});
        serve(0, "wr0");

        req = 4'b0101;
        serve(winner(req, exp_ptr), "pair_a");
        serve(winner(req, exp_ptr), "pair_b");
        req = 4'b0001;
        serve(0, "wrap");

        rnw_a[3] = 1'b1; size_a[3] = 3'd3;
        rd_bytes[0] = 8'h11; rd_bytes[1] = 8'h22; rd_bytes[2] = 8'h33;
        req = 4'b1000;
        serve(3, "rd3");

        hold_busy = 1'b1;
        repeat (3) @(negedge clk);
        req = 4'b0010;
        repeat (8) @(negedge clk);
        chk("busy_hold", grant, 0);
        hold_busy = 1'b0;
        repeat (2) @(negedge clk);
        chk("busy_sync", grant, 0);
        @(negedge clk);
        chk("busy_grant", grant, 4'b0010);
        serve(1, "busy");

        hang = 1'b1;
        req = 4'b0010;
        @(negedge clk);
        chk("to_start", {m.m_start, grant}, {1'b1, 4'b0010});
        n = 0;
        while (n < 40 && err == '0) begin
            @(negedge clk);
            n++;
        end
        chk("to_cycles", n, TO);
        chk("to_err", {err, done}, {4'b0010, 4'b0000});
        req = '0;
        @(negedge clk);
        chk("to_start_drop", {m.m_start, grant}, 0);
        hang = 1'b0;
        exp_ptr = 2;

        size_a[2] = 3'd3; rnw_a[2] = 1'b0;
        req = 4'b0100;
        n = 0;
        while (n < 40 && !(grant != '0 && !m.m_start)) begin
            @(negedge clk);
            n++;
        end
        chk("rst_run_reached", grant, 4'b0100);
        exp_grant = 4'b0100;
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1 chk("rst_async", {grant, m.m_start, wreq, done, err}, 0);
        exp_grant = '0;
        req = '0;
        exp_ptr = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        req = 4'b1010;
        serve(winner(req, exp_ptr), "post_rst_a");
        serve(winner(req, exp_ptr), "post_rst_b");

        for (int it = 0; it < 8; it++) begin
            for (int i = 0; i < N; i++) begin
                addr_a[i] = 7'($urandom); size_a[i] = 3'($urandom_range(0, 3));
                rnw_a[i] = 1'($urandom); wdata_a[i] = 8'($urandom);
            end
            for (int b = 0; b < 8; b++) rd_bytes[b] = 8'($urandom);
            pat = N'($urandom_range(1, (1 << N) - 1));
            req = pat;
            while (req != '0) serve(winner(req, exp_ptr), $sformatf("rnd%0d", it));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
